// File: rtl/nvdla_cacc_dlv_fifo.sv
// CACC delivery FIFO: buffers final-result atoms and serialises each into OUT_K-element beats toward SDP.
// Optional stall counter output is built when CACC_DLV_PERF_EN is defined.
module nvdla_cacc_dlv_fifo #(
  parameter int ATOMK       = 8,
  parameter int FINAL_WIDTH = 32,
  parameter int OUT_K       = 4,
  parameter int DEPTH       = 8
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rst,
  input  logic                           dlv_valid,
  input  logic                           dlv_mask,
  input  logic [ATOMK*FINAL_WIDTH-1:0]   dlv_data,
  input  logic [1:0]                     dlv_pd,
  output logic                           cacc2sdp_valid,
  input  logic                           cacc2sdp_ready,
  output logic [OUT_K*FINAL_WIDTH+1:0]   cacc2sdp_pd,
  output logic                           dlv_credit_vld,
  output logic                           dp2reg_done,
  output logic                           dlv_ovf_err
`ifdef CACC_DLV_PERF_EN
  ,output logic [31:0]                   dp2reg_stall_count
`endif
);

  localparam int DW    = ATOMK * FINAL_WIDTH;
  localparam int EW    = DW + 2;
  localparam int BDW   = OUT_K * FINAL_WIDTH;
  localparam int BEATS = ATOMK / OUT_K;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic           credit_q, credit_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;

  logic [EW-1:0]  rd_entry;
  logic [BDW-1:0] beat_data;
  logic           full, not_empty, last_beat, fire, pop, wr_req, wr;

  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign rd_entry  = mem_q[rd_ptr_q];
  assign last_beat = (beat_q == BCW'(BEATS - 1));
  assign fire      = not_empty & cacc2sdp_ready;
  assign pop       = fire & last_beat;
  assign wr_req    = dlv_valid & dlv_mask;
  // A full FIFO still accepts a write on the same edge that frees a slot.
  assign wr        = wr_req & (~full | pop);

  always_comb begin
    beat_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BCW'(b)) beat_data = rd_entry[b*BDW +: BDW];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    if (fire) beat_d = last_beat ? '0 : beat_q + BCW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr)   wr_ptr_d = wr_ptr_q + AW'(1);
    count_d  = count_q + CW'(wr) - CW'(pop);
    credit_d = pop;
    done_d   = pop & rd_entry[EW-1];
    ovf_d    = ovf_q | (wr_req & full & ~pop);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      credit_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      credit_q <= credit_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset; count gates every read.
  always_ff @(posedge nvdla_core_clk) begin
    if (wr) mem_q[wr_ptr_q] <= {dlv_pd, dlv_data};
  end

  assign cacc2sdp_valid = not_empty;
  assign cacc2sdp_pd    = {rd_entry[EW-1 -: 2] & {2{last_beat}}, beat_data};
  assign dlv_credit_vld = credit_q;
  assign dp2reg_done    = done_q;
  assign dlv_ovf_err    = ovf_q;

`ifdef CACC_DLV_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (done_q)
      stall_d = '0;
    else if (cacc2sdp_valid & ~cacc2sdp_ready & (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) stall_q <= '0;
    else                stall_q <= stall_d;
  end

  assign dp2reg_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_nvdla_cacc_dlv_fifo.sv
// Directed bench for nvdla_cacc_dlv_fifo: serialisation, credits, overflow, backpressure, reset, wrap.
module tb_nvdla_cacc_dlv_fifo;

  localparam int ATOMK = 8;
  localparam int FW    = 32;
  localparam int OUT_K = 4;
  localparam int DEPTH = 8;
  localparam int BEATS = ATOMK / OUT_K;
  localparam int PDW   = OUT_K * FW + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  dlv_valid, dlv_mask, ready;
  logic [ATOMK*FW-1:0]   dlv_data;
  logic [1:0]            dlv_pd;
  logic                  valid, credit, done, ovf;
  logic [PDW-1:0]        pd;
`ifdef CACC_DLV_PERF_EN
  logic [31:0]           stall_cnt;
  logic [31:0]           exp_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nvdla_cacc_dlv_fifo #(.ATOMK(ATOMK), .FINAL_WIDTH(FW), .OUT_K(OUT_K), .DEPTH(DEPTH)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .dlv_valid      (dlv_valid),
    .dlv_mask       (dlv_mask),
    .dlv_data       (dlv_data),
    .dlv_pd         (dlv_pd),
    .cacc2sdp_valid (valid),
    .cacc2sdp_ready (ready),
    .cacc2sdp_pd    (pd),
    .dlv_credit_vld (credit),
    .dp2reg_done    (done),
    .dlv_ovf_err    (ovf)
`ifdef CACC_DLV_PERF_EN
    ,.dp2reg_stall_count (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ATOMK*FW-1:0] mk(input int seed);
    logic [ATOMK*FW-1:0] d;
    for (int i = 0; i < ATOMK; i++) d[i*FW +: FW] = FW'(seed * 256 + i + 1);
    return d;
  endfunction

  function automatic logic [PDW-1:0] exp_beat(input int seed, input logic [1:0] p, input int b);
    logic [OUT_K*FW-1:0] d;
    for (int j = 0; j < OUT_K; j++) d[j*FW +: FW] = FW'(seed * 256 + b * OUT_K + j + 1);
    return {(b == BEATS - 1) ? p : 2'b00, d};
  endfunction

  // One clock edge; outputs are observed 1 time unit later.
  task automatic cyc();
`ifdef CACC_DLV_PERF_EN
    logic s_rst, s_done, s_stall;
    s_rst   = rst;
    s_done  = done;
    s_stall = valid & ~ready;
`endif
    @(posedge clk);
    #1;
`ifdef CACC_DLV_PERF_EN
    if (s_rst || s_done) exp_stall = '0;
    else if (s_stall && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
`endif
  endtask

  task automatic wr_entry(input int seed, input logic [1:0] p);
    dlv_valid = 1'b1; dlv_mask = 1'b1; dlv_data = mk(seed); dlv_pd = p;
    cyc();
    dlv_valid = 1'b0; dlv_mask = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    logic [PDW-1:0] prev_pd;
    logic prev_stall;
    rst = 1'b1; dlv_valid = 1'b0; dlv_mask = 1'b0; dlv_data = '0; dlv_pd = 2'b00; ready = 1'b0;
`ifdef CACC_DLV_PERF_EN
    exp_stall = '0;
`endif
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", valid, 1'b0);
    chk("rst_credit", credit, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
`ifdef CACC_DLV_PERF_EN
    chk("rst_stall", stall_cnt, 32'd0);
`endif

    // Single entry, ready high
    ready = 1'b1;
    wr_entry(0, 2'b11);
    chk("s_valid0", valid, 1'b1);
    chk("s_beat0", pd, exp_beat(0, 2'b11, 0));
    cyc();
    chk("s_beat1", pd, exp_beat(0, 2'b11, 1));
    chk("s_credit_early", credit, 1'b0);
    cyc();
    chk("s_credit", credit, 1'b1);
    chk("s_done", done, 1'b1);
    chk("s_empty", valid, 1'b0);
    cyc();
    chk("s_credit_off", credit, 1'b0);
    chk("s_done_off", done, 1'b0);

    // Fill with ready low, overflow, drain
    ready = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      wr_entry(1 + e, 2'b01);
      chk("f_no_credit", credit, 1'b0);
    end
    chk("f_ovf_before", ovf, 1'b0);
    wr_entry(99, 2'b11);
    chk("f_ovf", ovf, 1'b1);
    ready = 1'b1;
    for (int e = 0; e < DEPTH; e++) begin
      for (int b = 0; b < BEATS; b++) begin
        chk("f_valid", valid, 1'b1);
        chk("f_beat", pd, exp_beat(1 + e, 2'b01, b));
        cyc();
        chk("f_credit", credit, (b == BEATS - 1) ? 1'b1 : 1'b0);
      end
    end
    chk("f_drained", valid, 1'b0);
    chk("f_ovf_sticky", ovf, 1'b1);

    // Full plus simultaneous write and pop
    do_reset();
    chk("r_ovf_clear", ovf, 1'b0);
    ready = 1'b0;
    for (int e = 0; e < DEPTH; e++) wr_entry(11 + e, 2'b01);
    ready = 1'b1;
    chk("w_beat0", pd, exp_beat(11, 2'b01, 0));
    cyc();
    chk("w_beat1", pd, exp_beat(11, 2'b01, 1));
    wr_entry(11 + DEPTH, 2'b01);
    chk("w_no_ovf", ovf, 1'b0);
    for (int e = 1; e <= DEPTH; e++) begin
      for (int b = 0; b < BEATS; b++) begin
        chk("w_beat", pd, exp_beat(11 + e, 2'b01, b));
        cyc();
      end
    end
    chk("w_drained", valid, 1'b0);

    // Backpressure stability
    do_reset();
    ready = 1'b0;
    wr_entry(21, 2'b10);
    wr_entry(22, 2'b10);
    acc = 0;
    for (int i = 0; i < 200 && acc < 2 * BEATS; i++) begin
      ready = 1'($urandom_range(0, 1));
      chk("bp_beat", pd, exp_beat(21 + acc / BEATS, 2'b10, acc % BEATS));
      prev_pd    = pd;
      prev_stall = valid & ~ready;
      if (valid && ready) acc++;
      cyc();
      if (prev_stall) chk("bp_stable", pd, prev_pd);
`ifdef CACC_DLV_PERF_EN
      chk("bp_stall", stall_cnt, exp_stall);
`endif
    end
    chk("bp_complete", acc, 2 * BEATS);
    ready = 1'b0;
    cyc();
    chk("bp_empty", valid, 1'b0);
`ifdef CACC_DLV_PERF_EN
    chk("bp_stall_cleared", stall_cnt, 32'd0);
`endif

    // Reset mid-entry
    do_reset();
    ready = 1'b0;
    wr_entry(31, 2'b11);
    wr_entry(32, 2'b11);
    wr_entry(33, 2'b11);
    ready = 1'b1;
    chk("m_beat0", pd, exp_beat(31, 2'b11, 0));
    cyc();
    rst = 1'b1;
    cyc();
    chk("m_valid", valid, 1'b0);
    chk("m_credit", credit, 1'b0);
    chk("m_done", done, 1'b0);
    rst = 1'b0;
    wr_entry(34, 2'b11);
    chk("m_credit_after", credit, 1'b0);
    chk("m_fresh_beat0", pd, exp_beat(34, 2'b11, 0));
    cyc();
    chk("m_fresh_beat1", pd, exp_beat(34, 2'b11, 1));
    cyc();
    chk("m_fresh_credit", credit, 1'b1);
    chk("m_fresh_done", done, 1'b1);

    // Masked write, then streaming with pointer wrap
    dlv_valid = 1'b1; dlv_mask = 1'b0; dlv_data = mk(40); dlv_pd = 2'b11;
    cyc();
    dlv_valid = 1'b0;
    chk("k_masked", valid, 1'b0);
    wr_entry(50, 2'b00);
    for (int k = 0; k < 20; k++) begin
      chk("k_beat0", pd, exp_beat(50 + k, 2'(k), 0));
      cyc();
      chk("k_beat1", pd, exp_beat(50 + k, 2'(k), 1));
      if (k < 19) wr_entry(51 + k, 2'(k + 1));
      else cyc();
      chk("k_credit", credit, 1'b1);
    end
    chk("k_drained", valid, 1'b0);
    chk("k_no_ovf", ovf, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
